instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a three-state fetch/issue sequencer with a fetch timeout.
// It hands decoded instruction fields to the control unit and counts accepted instructions.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [31:0] pc_plus8,
  input  logic        cu_ready,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        fetch_err,
  output logic [31:0] issue_count
);

  // state | meaning
  // FETCH | imem_req high, waiting for imem_ack (bounded by TIMEOUT)
  // ISSUE | instruction held for the control unit until cu_ready
  // ERROR | fetch timed out; terminal until reset
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic          r_active;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_instr, w_instr_nxt;
  logic [31:0]   r_count, w_count_nxt;
  logic [CW-1:0] r_wait, w_wait_nxt;
  logic          r_err, w_err_nxt;
  logic          w_unused_bits;

  assign w_unused_bits = ^branch_target[1:0];

  // r_active holds the FSM idle for the first cycle out of reset, so imem_req
  // stays low during reset and an ack arriving right at release is not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FETCH;
      r_active <= 1'b0;
      r_pc     <= PC_INIT;
      r_instr  <= 32'h0;
      r_count  <= 32'h0;
      r_wait   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_count  <= w_count_nxt;
      r_wait   <= w_wait_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_count_nxt = r_count;
    w_wait_nxt  = r_wait;
    w_err_nxt   = r_err;
    case (r_state)
      FETCH: begin
        if (r_active) begin
          if (imem_ack) begin
            w_instr_nxt = imem_rdata;
            w_wait_nxt  = '0;
            w_state_nxt = ISSUE;
          end else if (r_wait == WAIT_LAST) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ERROR;
          end else begin
            w_wait_nxt = r_wait + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cu_ready) begin
          w_count_nxt = r_count + 32'd1;
          w_pc_nxt    = pc_src ? {branch_target[31:2], 2'b00} : r_pc + 32'd4;
          w_state_nxt = FETCH;
        end
      end
      ERROR: begin
        w_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign imem_req    = r_active && (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ISSUE);
  assign instr       = r_instr;
  assign cond        = r_instr[31:28];
  assign op          = r_instr[27:26];
  assign funct       = r_instr[25:20];
  assign rn          = r_instr[19:16];
  assign rd          = r_instr[15:12];
  assign pc_plus8    = r_pc + 32'd8;
  assign fetch_err   = r_err;
  assign issue_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: decode, accept, branch, stall, timeout, reset, PC wrap.
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_w;
  logic        imem_req, imem_ack, instr_valid, cu_ready, pc_src, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc_plus8, branch_target, issue_count;
  logic [3:0]  cond, rn, rd;
  logic [1:0]  op;
  logic [5:0]  funct;

  logic        w_req, w_ack, w_valid, w_ready, w_src, w_err;
  logic [31:0] w_addr, w_rdata, w_instr, w_p8, w_bt, w_count;
  logic [3:0]  w_cond, w_rn, w_rd;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr_valid(instr_valid),
    .instr(instr), .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd),
    .pc_plus8(pc_plus8), .cu_ready(cu_ready), .pc_src(pc_src),
    .branch_target(branch_target), .fetch_err(fetch_err), .issue_count(issue_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFE), .TIMEOUT(16)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_ack(w_ack), .instr_valid(w_valid),
    .instr(w_instr), .cond(w_cond), .op(w_op), .funct(w_funct), .rn(w_rn), .rd(w_rd),
    .pc_plus8(w_p8), .cu_ready(w_ready), .pc_src(w_src),
    .branch_target(w_bt), .fetch_err(w_err), .issue_count(w_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; cu_ready = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0; w_src = 1'b0; w_bt = 32'h0;
    step(2);

    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_count", issue_count, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    rst_n = 1'b1;
    step(1);
    chk("f1_req", {31'b0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'h0);
    chk("f1_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hE481_3004;
    step(1);
    imem_ack = 1'b0;
    chk("i1_valid", {31'b0, instr_valid}, 32'd1);
    chk("i1_req", {31'b0, imem_req}, 32'd0);
    chk("i1_instr", instr, 32'hE481_3004);
    chk("i1_cond", {28'b0, cond}, 32'hE);
    chk("i1_op", {30'b0, op}, 32'd1);
    chk("i1_funct", {26'b0, funct}, 32'h08);
    chk("i1_rn", {28'b0, rn}, 32'h1);
    chk("i1_rd", {28'b0, rd}, 32'h3);
    chk("i1_pc8", pc_plus8, 32'h8);

    // stall: toggling pc_src, a stray ack and a branch target must all be ignored
    for (int i = 0; i < 5; i++) begin
      pc_src = i[0]; branch_target = 32'h0000_0100; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step(1);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'hE481_3004);
      chk("stall_addr", imem_addr, 32'h0);
    end
    imem_ack = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    chk("stall_count", issue_count, 32'd0);

    cu_ready = 1'b1;
    step(1);
    cu_ready = 1'b0;
    chk("a1_req", {31'b0, imem_req}, 32'd1);
    chk("a1_addr", imem_addr, 32'h4);
    chk("a1_count", issue_count, 32'd1);
    chk("a1_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hE594_9010;
    step(1);
    imem_ack = 1'b0;
    chk("i2_cond", {28'b0, cond}, 32'hE);
    chk("i2_op", {30'b0, op}, 32'd1);
    chk("i2_funct", {26'b0, funct}, 32'h19);
    chk("i2_rn", {28'b0, rn}, 32'h4);
    chk("i2_rd", {28'b0, rd}, 32'h9);
    chk("i2_pc8", pc_plus8, 32'hC);

    cu_ready = 1'b1;
    step(1);
    cu_ready = 1'b0;
    chk("a2_addr", imem_addr, 32'h8);
    chk("a2_count", issue_count, 32'd2);
    imem_ack = 1'b1; imem_rdata = 32'hBA00_0003;
    step(1);
    imem_ack = 1'b0;
    chk("i3_cond", {28'b0, cond}, 32'hB);
    chk("i3_op", {30'b0, op}, 32'd2);
    chk("i3_funct", {26'b0, funct}, 32'h20);
    chk("i3_pc8", pc_plus8, 32'h10);

    cu_ready = 1'b1; pc_src = 1'b1; branch_target = 32'h0000_0023;
    step(1);
    cu_ready = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    chk("br_addr", imem_addr, 32'h20);
    chk("br_count", issue_count, 32'd3);
    chk("br_req", {31'b0, imem_req}, 32'd1);

    // timeout: 15 ack-less cycles still fetching, the 16th ends in ERROR
    step(15);
    chk("to15_err", {31'b0, fetch_err}, 32'd0);
    chk("to15_req", {31'b0, imem_req}, 32'd1);
    step(1);
    chk("to16_err", {31'b0, fetch_err}, 32'd1);
    chk("to16_req", {31'b0, imem_req}, 32'd0);
    chk("to16_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    step(3);
    imem_ack = 1'b0;
    chk("err_ack_err", {31'b0, fetch_err}, 32'd1);
    chk("err_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("err_ack_instr", instr, 32'hBA00_0003);
    chk("err_ack_req", {31'b0, imem_req}, 32'd0);

    rst_n = 1'b0;
    #1;
    chk("rp_err", {31'b0, fetch_err}, 32'd0);
    chk("rp_count", issue_count, 32'd0);
    chk("rp_addr", imem_addr, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step(1);
    imem_ack = 1'b0;
    chk("r2_valid", {31'b0, instr_valid}, 32'd1);
    chk("r2_instr", instr, 32'h1234_5678);

    // reset mid-ISSUE, with a late ack still asserted as reset releases
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_instr", instr, 32'h0);
    chk("mid_req", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    step(1);
    rst_n = 1'b1;
    step(1);
    imem_ack = 1'b0;
    chk("late_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_instr", instr, 32'h0);
    chk("late_req", {31'b0, imem_req}, 32'd1);

    // second instance: RESET_PC low bits are dropped and pc+4 wraps to zero
    rst_n_w = 1'b1;
    step(1);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    chk("w_req0", {31'b0, w_req}, 32'd1);
    w_ack = 1'b1; w_rdata = 32'hE000_0000;
    step(1);
    w_ack = 1'b0;
    chk("w_valid", {31'b0, w_valid}, 32'd1);
    chk("w_pc8", w_p8, 32'h0000_0004);
    w_ready = 1'b1;
    step(1);
    w_ready = 1'b0;
    chk("w_wrap_addr", w_addr, 32'h0);
    chk("w_count", w_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
